// File: rtl/vga_scanout_if.sv
// Video RAM port B read bus between the scan-out master and the framebuffer.
interface vga_scanout_if;
    logic [11:0] vga_addr;
    logic [7:0]  vga_color;

    modport master (output vga_addr, input vga_color);
    modport slave  (input vga_addr, output vga_color);
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out master: sweeps H/V timing, reads one framebuffer cell per CELLxCELL block and drives
// 3/3/2 colour with syncs. Define VGA_TEST_PATTERN_EN to replace RAM data with a cell pattern.
module vga_scanout #(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CELL     = 10,
    parameter int unsigned FB_COLS  = 64
) (
    input  logic          clk,
    input  logic          reset,
    vga_scanout_if.master mem,
    output logic [2:0]    vga_r,
    output logic [2:0]    vga_g,
    output logic [1:0]    vga_b,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW        = $clog2(H_TOTAL);
    localparam int unsigned VW        = $clog2(V_TOTAL);
    localparam int unsigned DW        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned SW        = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int unsigned COL_SHIFT = $clog2(FB_COLS);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d, col_q, col_d;
    logic [VW-1:0] v_q, v_d, row_q, row_d;
    logic [SW-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
    logic [11:0]   addr_q, addr_d;
    logic          pix_en;
    logic          addr_active;

    assign pix_en = (32'(div_q) == PIX_DIV - 1);

    // Cell column/row come from sub-counters so no divider or multiplier is needed.
    always_comb begin
        div_d  = pix_en ? '0 : div_q + DW'(1);
        h_d    = h_q;
        hsub_d = hsub_q;
        col_d  = col_q;
        v_d    = v_q;
        vsub_d = vsub_q;
        row_d  = row_q;
        if (pix_en) begin
            if (32'(h_q) == H_TOTAL - 1) begin
                h_d    = '0;
                hsub_d = '0;
                col_d  = '0;
                if (32'(v_q) == V_TOTAL - 1) begin
                    v_d    = '0;
                    vsub_d = '0;
                    row_d  = '0;
                end else begin
                    v_d = v_q + VW'(1);
                    if (32'(vsub_q) == CELL - 1) begin
                        vsub_d = '0;
                        row_d  = row_q + VW'(1);
                    end else begin
                        vsub_d = vsub_q + SW'(1);
                    end
                end
            end else begin
                h_d = h_q + HW'(1);
                if (32'(hsub_q) == CELL - 1) begin
                    hsub_d = '0;
                    col_d  = col_q + HW'(1);
                end else begin
                    hsub_d = hsub_q + SW'(1);
                end
            end
        end
        addr_active = (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
        addr_d      = addr_active ? 12'((32'(row_d) << COL_SHIFT) | 32'(col_d)) : '0;
    end

    // S0: counters and the address they select.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            h_q    <= '0;
            hsub_q <= '0;
            col_q  <= '0;
            v_q    <= '0;
            vsub_q <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            hsub_q <= hsub_d;
            col_q  <= col_d;
            v_q    <= v_d;
            vsub_q <= vsub_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign mem.vga_addr = addr_q;

    // S1: timing flags delayed to line up with the RAM's registered read data.
    logic act1_q, hs1_q, vs1_q, first1_q;
    logic [7:0] pix_color;

`ifdef VGA_TEST_PATTERN_EN
    logic [7:0] pat1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat1_q <= '0;
        end else begin
            pat1_q <= {col_q[2:0], row_q[2:0], col_q[4:3]};
        end
    end

    assign pix_color = pat1_q;
`else
    assign pix_color = mem.vga_color;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            act1_q   <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            first1_q <= 1'b0;
        end else begin
            act1_q   <= (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
            hs1_q    <= !((32'(h_q) >= H_ACTIVE + H_FP) &&
                          (32'(h_q) < H_ACTIVE + H_FP + H_SYNC));
            vs1_q    <= !((32'(v_q) >= V_ACTIVE + V_FP) &&
                          (32'(v_q) < V_ACTIVE + V_FP + V_SYNC));
            first1_q <= (h_q == '0) && (v_q == '0) && (div_q == '0);
        end
    end

    // S2: registered outputs; blanking forces black regardless of RAM data.
    logic [7:0] rgb_q;
    logic       hsync_q, vsync_q, fs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= act1_q ? pix_color : 8'h00;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
            fs_q    <= first1_q;
        end
    end

    assign vga_r       = rgb_q[7:5];
    assign vga_g       = rgb_q[4:2];
    assign vga_b       = rgb_q[1:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on shrunk timing (104x48 total, 80x40 active, 10-pixel cells) so that
// whole frames fit in a short run; a second instance exercises PIX_DIV=1.
module tb_vga_scanout;
    localparam int unsigned HT    = 104;
    localparam int unsigned VT    = 48;
    localparam int unsigned PD    = 2;
    localparam int unsigned FRAME = HT * VT * PD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic force_ff = 1'b0;

    always #5 clk = ~clk;

    vga_scanout_if bus0 ();
    vga_scanout_if bus1 ();

    logic [2:0] r0, g0, r1, g1;
    logic [1:0] b0, b1;
    logic       hs0, vs0, fs0, hs1, vs1, fs1;

    vga_scanout #(
        .PIX_DIV(2), .H_ACTIVE(80), .H_FP(8), .H_SYNC(12), .H_BP(4),
        .V_ACTIVE(40), .V_FP(3), .V_SYNC(2), .V_BP(3), .CELL(10), .FB_COLS(64)
    ) dut0 (
        .clk(clk), .reset(reset), .mem(bus0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .hsync(hs0), .vsync(vs0), .frame_start(fs0)
    );

    vga_scanout #(
        .PIX_DIV(1), .H_ACTIVE(80), .H_FP(8), .H_SYNC(12), .H_BP(4),
        .V_ACTIVE(40), .V_FP(3), .V_SYNC(2), .V_BP(3), .CELL(10), .FB_COLS(64)
    ) dut1 (
        .clk(clk), .reset(reset), .mem(bus1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .hsync(hs1), .vsync(vs1), .frame_start(fs1)
    );

    // Video RAM port B: registered read, mem[a] = a[7:0].
    always @(posedge clk) begin
        bus0.vga_color <= force_ff ? 8'hFF : bus0.vga_addr[7:0];
        bus1.vga_color <= bus1.vga_addr[7:0];
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] exp_active(input int unsigned h, input int unsigned v);
        int unsigned c;
        int unsigned r;
        c = h / 10;
        r = v / 10;
`ifdef VGA_TEST_PATTERN_EN
        return {c[2:0], r[2:0], c[4:3]};
`else
        return force_ff ? 8'hFF : 8'((r * 64 + c) & 255);
`endif
    endfunction

    typedef struct {
        int unsigned f, h, v, ph;
        logic [7:0]  rgb, pat;
        logic        hs, vs, fs;
        logic [11:0] addr;
    } vec_t;

    vec_t vecs[21];

    initial begin
        int cur;
        int t;
        logic [7:0] er;
        int errs, hs_low, vs_low, fs_n, fs_pos2;

        // {frame, h, v, phase, rgb, pattern rgb, hsync, vsync, frame_start, addr of state then}
        vecs[0]  = '{0,   0,  0, 0, 8'h00, 8'h00, 1, 1, 1, 12'd0};
        vecs[1]  = '{0,   0,  0, 1, 8'h00, 8'h00, 1, 1, 0, 12'd0};
        vecs[2]  = '{0,   9,  0, 0, 8'h00, 8'h00, 1, 1, 0, 12'd1};
        vecs[3]  = '{0,  10,  0, 0, 8'h01, 8'h20, 1, 1, 0, 12'd1};
        vecs[4]  = '{0,  80,  0, 0, 8'h00, 8'h00, 1, 1, 0, 12'd0};
        vecs[5]  = '{0,  87,  0, 1, 8'h00, 8'h00, 1, 1, 0, 12'd0};
        vecs[6]  = '{0,  88,  0, 0, 8'h00, 8'h00, 0, 1, 0, 12'd0};
        vecs[7]  = '{0,  99,  0, 1, 8'h00, 8'h00, 0, 1, 0, 12'd0};
        vecs[8]  = '{0, 100,  0, 0, 8'h00, 8'h00, 1, 1, 0, 12'd0};
        vecs[9]  = '{0,   0, 10, 0, 8'h40, 8'h04, 1, 1, 0, 12'd64};
        vecs[10] = '{0,  39, 19, 1, 8'h43, 8'h64, 1, 1, 0, 12'd68};
        vecs[11] = '{0,  35, 27, 0, 8'h83, 8'h68, 1, 1, 0, 12'd131};
        vecs[12] = '{0,  78, 39, 0, 8'hC7, 8'hEC, 1, 1, 0, 12'd199};
        vecs[13] = '{0,  79, 39, 0, 8'hC7, 8'hEC, 1, 1, 0, 12'd0};
        vecs[14] = '{0,   0, 40, 0, 8'h00, 8'h00, 1, 1, 0, 12'd0};
        vecs[15] = '{0,   0, 43, 0, 8'h00, 8'h00, 1, 0, 0, 12'd0};
        vecs[16] = '{0,  50, 44, 1, 8'h00, 8'h00, 1, 0, 0, 12'd0};
        vecs[17] = '{0,   0, 45, 0, 8'h00, 8'h00, 1, 1, 0, 12'd0};
        vecs[18] = '{0, 103, 47, 1, 8'h00, 8'h00, 1, 1, 0, 12'd0};
        vecs[19] = '{1,   0,  0, 0, 8'h00, 8'h00, 1, 1, 1, 12'd0};
        vecs[20] = '{1,  10,  0, 1, 8'h01, 8'h20, 1, 1, 0, 12'd1};

        // Reset held 5 clk: idle output levels on both instances.
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst rgb0", {r0, g0, b0}, 8'h00);
        check("rst sync0", {hs0, vs0, fs0}, 3'b110);
        check("rst addr0", bus0.vga_addr, 12'd0);
        check("rst rgb1", {r1, g1, b1}, 8'h00);
        check("rst sync1", {hs1, vs1, fs1}, 3'b110);
        reset = 1'b0;

        // Table walk over two frames; target = output interval for pixel (h,v) plus 2-clk lag.
        cur = 0;
        for (int i = 0; i < 21; i++) begin
            t = 2 + int'(((vecs[i].f * VT + vecs[i].v) * HT + vecs[i].h) * PD + vecs[i].ph);
            repeat (t - cur) @(negedge clk);
            cur = t;
`ifdef VGA_TEST_PATTERN_EN
            er = vecs[i].pat;
`else
            er = vecs[i].rgb;
`endif
            check($sformatf("vec%0d rgb", i), {r0, g0, b0}, er);
            check($sformatf("vec%0d hsync", i), hs0, vecs[i].hs);
            check($sformatf("vec%0d vsync", i), vs0, vecs[i].vs);
            check($sformatf("vec%0d frame_start", i), fs0, vecs[i].fs);
            check($sformatf("vec%0d addr", i), bus0.vga_addr, vecs[i].addr);
        end

        // PIX_DIV=1 instance: one clk per pixel.
        do_reset(2);
        repeat (2) @(negedge clk);
        check("div1 fs@2", fs1, 1'b1);
        @(negedge clk);
        check("div1 fs@3", fs1, 1'b0);
        repeat (9) @(negedge clk);
`ifdef VGA_TEST_PATTERN_EN
        check("div1 rgb(10,0)", {r1, g1, b1}, 8'h20);
`else
        check("div1 rgb(10,0)", {r1, g1, b1}, 8'h01);
`endif
        repeat (77) @(negedge clk);
        check("div1 hsync@89", hs1, 1'b1);
        @(negedge clk);
        check("div1 hsync@90", hs1, 1'b0);

        // Two frames with RAM data forced to 0xFF: blanking and sync/frame counts.
        force_ff = 1'b1;
        do_reset(3);
        errs = 0;
        hs_low = 0;
        vs_low = 0;
        fs_n = 0;
        fs_pos2 = 0;
        for (int m = 0; m < 2 + 2 * int'(FRAME); m++) begin
            if (m >= 2) begin
                int unsigned p, h, v;
                p = (m - 2) / PD;
                h = p % HT;
                v = (p / HT) % VT;
                er = (h < 80 && v < 40) ? exp_active(h, v) : 8'h00;
                if ({r0, g0, b0} !== er) begin
                    if (errs == 0)
                        $display("FAIL blank first at (%0d,%0d): got %0h want %0h",
                                 h, v, {r0, g0, b0}, er);
                    errs++;
                end
                if (hs0 == 1'b0) hs_low++;
                if (vs0 == 1'b0) vs_low++;
                if (fs0 == 1'b1) begin
                    fs_n++;
                    if (fs_n == 2) fs_pos2 = m;
                end
            end
            @(negedge clk);
        end
        check("blank mismatches", errs, 0);
        check("hsync low clks", hs_low, 2 * 12 * PD * VT);
        check("vsync low clks", vs_low, 2 * 2 * HT * PD);
        check("frame_start count", fs_n, 2);
        check("frame_start period", fs_pos2, 2 + FRAME);
        force_ff = 1'b0;

        // One-clk reset at pixel (30,20) restarts the sweep from (0,0).
        do_reset(2);
        repeat ((20 * HT + 30) * PD) @(negedge clk);
`ifdef VGA_TEST_PATTERN_EN
        check("pre rgb(29,20)", {r0, g0, b0}, 8'h48);
`else
        check("pre rgb(29,20)", {r0, g0, b0}, 8'h82);
`endif
        check("pre addr(30,20)", bus0.vga_addr, 12'd131);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid rst rgb", {r0, g0, b0}, 8'h00);
        check("mid rst sync", {hs0, vs0, fs0}, 3'b110);
        check("mid rst addr", bus0.vga_addr, 12'd0);
        @(negedge clk);
        check("mid fs@1", fs0, 1'b0);
        @(negedge clk);
        check("mid fs@2", fs0, 1'b1);
        check("mid rgb@2", {r0, g0, b0}, 8'h00);
        repeat (20) @(negedge clk);
`ifdef VGA_TEST_PATTERN_EN
        check("mid rgb(10,0)", {r0, g0, b0}, 8'h20);
`else
        check("mid rgb(10,0)", {r0, g0, b0}, 8'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
